// File: rtl/ddr_seq_pkg.sv
// ddr_seq_pkg: state encoding and default widths shared by the DDR burst sequencer
package ddr_seq_pkg;
    localparam int ADDR_W_DEF = 25;
    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 10;
    localparam int SKID_DEPTH = 2;
    localparam int SKID_CW    = $clog2(SKID_DEPTH + 1);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_CMD,
        S_WR_DATA,
        S_RD_CMD,
        S_RD_DATA,
        S_GUARD
    } seq_state_t;
endpackage

// File: rtl/ddr_burst_sequencer_skid_buf.sv
// ddr_skid_buf: 2-entry write-path buffer between the FIFO q and the memory write port
module ddr_skid_buf
    import ddr_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic               clk_ref,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               push,
    input  logic [DATA_W-1:0]  push_data,
    output logic               valid,
    output logic [DATA_W-1:0]  data,
    input  logic               rdy,
    output logic [SKID_CW-1:0] free
);
    logic [DATA_W-1:0]  mem [SKID_DEPTH];
    logic               wr_ptr, rd_ptr, pop;
    logic [SKID_CW-1:0] cnt;

    assign valid = cnt != '0;
    assign data  = mem[rd_ptr];
    assign pop   = valid && rdy;
    assign free  = SKID_CW'(SKID_DEPTH) - cnt;

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= '0;
        end else begin
            if (push) mem[wr_ptr] <= push_data;
            wr_ptr <= wr_ptr ^ push;
            rd_ptr <= rd_ptr ^ pop;
            cnt    <= cnt + SKID_CW'(push) - SKID_CW'(pop);
        end
    end
endmodule

// File: rtl/ddr_burst_sequencer.sv
// ddr_burst_sequencer: write-priority burst arbiter between the frame FIFO controller and a DDR port.
// Optional watchdog enabled with `define DDR_SEQ_TIMEOUT_EN.
module ddr_burst_sequencer
    import ddr_seq_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int LEN_W       = LEN_W_DEF,
    parameter int GUARD_CYC   = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk_ref,
    input  logic              rst_n,
    input  logic              ddr_init_done,
    input  logic              ddr_wr_req,
    input  logic [ADDR_W-1:0] ddr_wraddr,
    input  logic [LEN_W-1:0]  wr_length,
    output logic              ddr_wr_ack,
    input  logic [DATA_W-1:0] ddr_din,
    output logic              ddr_wr_finish,
    input  logic              ddr_rd_req,
    input  logic [ADDR_W-1:0] ddr_rdaddr,
    input  logic [LEN_W-1:0]  rd_length,
    output logic              ddr_rd_ack,
    output logic [DATA_W-1:0] ddr_dout,
    output logic              ddr_rd_finish,
    output logic              mem_cmd_en,
    input  logic              mem_cmd_rdy,
    output logic              mem_cmd_wr,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [LEN_W-1:0]  mem_cmd_len,
    output logic              mem_wvalid,
    input  logic              mem_wrdy,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              seq_err
);
    localparam int GW = $clog2(GUARD_CYC + 1);

    seq_state_t         state, state_nxt;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   len_q, ack_cnt, beat_cnt;
    logic [GW-1:0]      guard_cnt;
    logic [SKID_CW-1:0] sk_free;
    logic [DATA_W-1:0]  sk_data, dout_q;
    logic sk_valid, sk_rdy, wr_pop, rd_beat, ack_d, last_beat, cmd_acc;
    logic wr_grant, rd_grant, to_hit, wr_fin_q, rd_fin_q, rd_ack_q;

    assign wr_grant      = ddr_init_done && ddr_wr_req && wr_length != '0;
    assign rd_grant      = ddr_init_done && ddr_rd_req && rd_length != '0;
    assign cmd_acc       = mem_cmd_en && mem_cmd_rdy;
    assign sk_rdy        = mem_wrdy && state == S_WR_DATA;
    assign wr_pop        = sk_valid && sk_rdy;
    assign rd_beat       = mem_rvalid && state == S_RD_DATA;
    assign last_beat     = beat_cnt == len_q - LEN_W'(1);
    assign mem_cmd_addr  = addr_q;
    assign mem_cmd_len   = len_q;
    assign mem_wvalid    = sk_valid && state == S_WR_DATA;
    assign mem_wdata     = sk_data;
    assign ddr_wr_finish = wr_fin_q;
    assign ddr_rd_finish = rd_fin_q;
    assign ddr_rd_ack    = rd_ack_q;
    assign ddr_dout      = dout_q;

    // Ack only when the entry it will occupy a cycle later is guaranteed free, counting the one in flight.
    always_comb begin
        state_nxt  = state;
        mem_cmd_en = state == S_WR_CMD || state == S_RD_CMD;
        mem_cmd_wr = state == S_WR_CMD;
        ddr_wr_ack = state == S_WR_DATA && ack_cnt < len_q &&
                     ({1'b0, sk_free} + {{SKID_CW{1'b0}}, wr_pop}) > {{SKID_CW{1'b0}}, ack_d};
        case (state)
            S_IDLE:    state_nxt = wr_grant ? S_WR_CMD : rd_grant ? S_RD_CMD : S_IDLE;
            S_WR_CMD:  state_nxt = to_hit ? S_GUARD : cmd_acc ? S_WR_DATA : S_WR_CMD;
            S_RD_CMD:  state_nxt = to_hit ? S_GUARD : cmd_acc ? S_RD_DATA : S_RD_CMD;
            S_WR_DATA: state_nxt = (to_hit || (wr_pop && last_beat)) ? S_GUARD : S_WR_DATA;
            S_RD_DATA: state_nxt = (to_hit || (rd_beat && last_beat)) ? S_GUARD : S_RD_DATA;
            S_GUARD:   state_nxt = guard_cnt == GW'(GUARD_CYC - 1) ? S_IDLE : S_GUARD;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            len_q     <= '0;
            ack_cnt   <= '0;
            beat_cnt  <= '0;
            guard_cnt <= '0;
            ack_d     <= 1'b0;
            wr_fin_q  <= 1'b0;
            rd_fin_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            dout_q    <= '0;
        end else begin
            ack_d     <= ddr_wr_ack;
            rd_ack_q  <= rd_beat;
            wr_fin_q  <= (wr_pop && last_beat) || (to_hit && (state == S_WR_CMD || state == S_WR_DATA));
            rd_fin_q  <= (rd_beat && last_beat) || (to_hit && (state == S_RD_CMD || state == S_RD_DATA));
            guard_cnt <= state == S_GUARD ? guard_cnt + GW'(1) : '0;
            if (rd_beat) dout_q <= mem_rdata;
            if (state == S_IDLE) begin
                ack_cnt  <= '0;
                beat_cnt <= '0;
                if (wr_grant || rd_grant) begin
                    addr_q <= wr_grant ? ddr_wraddr : ddr_rdaddr;
                    len_q  <= wr_grant ? wr_length : rd_length;
                end
            end else begin
                if (ddr_wr_ack) ack_cnt <= ack_cnt + LEN_W'(1);
                if (wr_pop || rd_beat) beat_cnt <= beat_cnt + LEN_W'(1);
            end
        end
    end

    ddr_skid_buf #(.DATA_W(DATA_W)) u_skid (
        .clk_ref   (clk_ref),
        .rst_n     (rst_n),
        .flush     (state != S_WR_DATA),
        .push      (ack_d && state == S_WR_DATA),
        .push_data (ddr_din),
        .valid     (sk_valid),
        .data      (sk_data),
        .rdy       (sk_rdy),
        .free      (sk_free)
    );

`ifdef DDR_SEQ_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);
    logic [WDW-1:0] wd_cnt;
    logic           wd_active, wd_progress, err_q;

    assign wd_active   = state inside {S_WR_CMD, S_WR_DATA, S_RD_CMD, S_RD_DATA};
    assign wd_progress = cmd_acc || wr_pop || rd_beat;
    assign to_hit      = wd_active && !wd_progress && wd_cnt == WDW'(TIMEOUT_CYC - 1);
    assign seq_err     = err_q;

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            wd_cnt <= (wd_active && !wd_progress && !to_hit) ? wd_cnt + WDW'(1) : '0;
            err_q  <= err_q || to_hit;
        end
    end
`else
    assign to_hit  = 1'b0;
    assign seq_err = 1'b0;
`endif
endmodule

// File: tb/tb_ddr_burst_sequencer.sv
// tb_ddr_burst_sequencer: directed self-checking bench for ddr_burst_sequencer
module tb_ddr_burst_sequencer;
    localparam int ADDR_W = 25;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 10;
    localparam logic [31:0] WBASE = 32'hA000_0000;
    localparam logic [31:0] RBASE = 32'h5000_0000;

    logic clk_ref = 1'b0, rst_n = 1'b0, ddr_init_done = 1'b0;
    logic ddr_wr_req = 1'b0, ddr_rd_req = 1'b0, mem_cmd_rdy = 1'b0, mem_wrdy = 1'b0, mem_rvalid = 1'b0;
    logic [ADDR_W-1:0] ddr_wraddr = '0, ddr_rdaddr = '0;
    logic [LEN_W-1:0]  wr_length = '0, rd_length = '0;
    logic [DATA_W-1:0] ddr_din = '0, mem_rdata = '0;
    logic ddr_wr_ack, ddr_wr_finish, ddr_rd_ack, ddr_rd_finish, mem_cmd_en, mem_cmd_wr, mem_wvalid, seq_err;
    logic [DATA_W-1:0] ddr_dout, mem_wdata;
    logic [ADDR_W-1:0] mem_cmd_addr;
    logic [LEN_W-1:0]  mem_cmd_len;

    always #5 clk_ref = ~clk_ref;

    ddr_burst_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .GUARD_CYC(2), .TIMEOUT_CYC(16)) dut (
        .clk_ref(clk_ref), .rst_n(rst_n), .ddr_init_done(ddr_init_done),
        .ddr_wr_req(ddr_wr_req), .ddr_wraddr(ddr_wraddr), .wr_length(wr_length),
        .ddr_wr_ack(ddr_wr_ack), .ddr_din(ddr_din), .ddr_wr_finish(ddr_wr_finish),
        .ddr_rd_req(ddr_rd_req), .ddr_rdaddr(ddr_rdaddr), .rd_length(rd_length),
        .ddr_rd_ack(ddr_rd_ack), .ddr_dout(ddr_dout), .ddr_rd_finish(ddr_rd_finish),
        .mem_cmd_en(mem_cmd_en), .mem_cmd_rdy(mem_cmd_rdy), .mem_cmd_wr(mem_cmd_wr),
        .mem_cmd_addr(mem_cmd_addr), .mem_cmd_len(mem_cmd_len),
        .mem_wvalid(mem_wvalid), .mem_wrdy(mem_wrdy), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .seq_err(seq_err)
    );

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int n_ack = 0, n_beat = 0, n_din = 0, n_wfin = 0, n_rack = 0, n_rsent = 0, n_rfin = 0, n_cmd = 0;
    int cyc = 0, t_wfin = 0, t_rcmd = 0, occ = 0, max_occ = 0, rack_at_rfin = 0, ack_at_wfin = 0;
    logic ack_pend = 1'b0, ackd_prev = 1'b0, cmd_en_prev = 1'b0, last_wr = 1'b0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [LEN_W-1:0]  last_len = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample at negedge, then model the FIFO q update just after posedge.
    task automatic tick();
        @(negedge clk_ref);
        cyc++;
        if (mem_cmd_en && mem_cmd_rdy) begin
            n_cmd++;
            last_wr = mem_cmd_wr;
            last_addr = mem_cmd_addr;
            last_len = mem_cmd_len;
        end
        if (mem_cmd_en && !mem_cmd_wr && !cmd_en_prev) t_rcmd = cyc;
        cmd_en_prev = mem_cmd_en;
        if (mem_wvalid && mem_wrdy) begin
            chk("wdata", mem_wdata, WBASE + n_beat);
            n_beat++;
        end
        occ = occ + int'(ackd_prev) - int'(mem_wvalid && mem_wrdy);
        if (occ > max_occ) max_occ = occ;
        ackd_prev = ddr_wr_ack;
        if (ddr_wr_ack) n_ack++;
        if (ddr_wr_finish) begin
            n_wfin++;
            t_wfin = cyc;
            ack_at_wfin = n_ack;
        end
        if (ddr_rd_ack) begin
            chk("rdata", ddr_dout, RBASE + n_rack);
            n_rack++;
        end
        if (ddr_rd_finish) begin
            n_rfin++;
            rack_at_rfin = n_rack;
            if (!seq_err) chk("rfin_with_ack", ddr_rd_ack, 1);
        end
        ack_pend = ddr_wr_ack;
        @(posedge clk_ref);
        #1;
        if (ack_pend) begin
            ddr_din = WBASE + n_din;
            n_din++;
        end
    endtask

    task automatic wait_cmd(input int target);
        for (int i = 0; i < 50 && n_cmd < target; i++) tick();
        chk("cmd_accepted", n_cmd, target);
    endtask

    task automatic wait_wfin(input int target);
        for (int i = 0; i < 300 && n_wfin < target; i++) tick();
        chk("wr_finish_seen", n_wfin, target);
    endtask

    task automatic wait_rfin(input int target);
        for (int i = 0; i < 100 && n_rfin < target; i++) tick();
        chk("rd_finish_seen", n_rfin, target);
    endtask

    task automatic rbeat(input logic v);
        mem_rvalid = v;
        if (v) begin
            mem_rdata = RBASE + n_rsent;
            n_rsent++;
        end
        tick();
        mem_rvalid = 1'b0;
    endtask

    initial begin
        int a0, b0, f0, r0, c0;
        logic [7:0] pat;
        repeat (3) @(posedge clk_ref);
        #1;
        chk("rst_wr_ack", ddr_wr_ack, 0);
        chk("rst_cmd_en", mem_cmd_en, 0);
        chk("rst_wvalid", mem_wvalid, 0);
        chk("rst_rd_ack", ddr_rd_ack, 0);
        chk("rst_dout", ddr_dout, 0);
        chk("rst_finish", {ddr_wr_finish, ddr_rd_finish, seq_err}, 0);
        rst_n = 1'b1;
        ddr_init_done = 1'b1;
        mem_cmd_rdy = 1'b1;
        mem_wrdy = 1'b1;

        // 1: single write burst, len 8
        a0 = n_ack; b0 = n_beat;
        ddr_wraddr = 25'h100; wr_length = 10'd8; ddr_wr_req = 1'b1;
        wait_cmd(1);
        ddr_wr_req = 1'b0;
        chk("t1_cmd", {last_wr, 7'd0, last_addr, 6'd0, last_len}, {1'b1, 7'd0, 25'h100, 6'd0, 10'd8});
        wait_wfin(1);
        chk("t1_acks_at_finish", ack_at_wfin - a0, 8);
        repeat (5) tick();
        chk("t1_acks", n_ack - a0, 8);
        chk("t1_beats", n_beat - b0, 8);
        chk("t1_one_finish", n_wfin, 1);

        // 2: both requests -> write first, then read after guard
        ddr_wraddr = 25'h200; wr_length = 10'd4; ddr_wr_req = 1'b1;
        ddr_rdaddr = 25'h300; rd_length = 10'd2; ddr_rd_req = 1'b1;
        wait_cmd(2);
        ddr_wr_req = 1'b0;
        chk("t2_write_wins", {last_wr, 7'd0, last_addr}, {1'b1, 7'd0, 25'h200});
        wait_wfin(2);
        wait_cmd(3);
        ddr_rd_req = 1'b0;
        chk("t2_read_cmd", {last_wr, 7'd0, last_addr, 6'd0, last_len}, {1'b0, 7'd0, 25'h300, 6'd0, 10'd2});
        chk("t2_guard_gap", t_rcmd - t_wfin, 3);
        rbeat(1'b1);
        rbeat(1'b1);
        wait_rfin(1);

        // 3: wrdy toggling, len 16
        a0 = n_ack; b0 = n_beat; max_occ = 0;
        ddr_wraddr = 25'h400; wr_length = 10'd16; ddr_wr_req = 1'b1;
        wait_cmd(4);
        ddr_wr_req = 1'b0;
        for (int i = 0; i < 300 && n_wfin < 3; i++) begin
            mem_wrdy = ~mem_wrdy;
            tick();
        end
        chk("t3_finish", n_wfin, 3);
        mem_wrdy = 1'b1;
        repeat (4) tick();
        chk("t3_acks", n_ack - a0, 16);
        chk("t3_beats", n_beat - b0, 16);
        chk("t3_skid_le2", max_occ <= 2, 1);

        // 4: read len 4 with gaps; stray rvalid before data phase ignored
        r0 = n_rack;
        mem_cmd_rdy = 1'b0;
        ddr_rdaddr = 25'h800; rd_length = 10'd4; ddr_rd_req = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        repeat (3) tick();
        mem_rvalid = 1'b0;
        chk("t4_stray_rvalid", n_rack - r0, 0);
        chk("t4_cmd_held", {mem_cmd_en, mem_cmd_wr, 6'd0, mem_cmd_addr}, {1'b1, 1'b0, 6'd0, 25'h800});
        mem_cmd_rdy = 1'b1;
        wait_cmd(5);
        ddr_rd_req = 1'b0;
        pat = 8'b1010_1001;
        for (int i = 0; i < 8; i++) rbeat(pat[i]);
        wait_rfin(2);
        chk("t4_acks_at_finish", rack_at_rfin - r0, 4);
        r0 = n_rack;
        rd_length = 10'd1; ddr_rd_req = 1'b1;
        wait_cmd(6);
        ddr_rd_req = 1'b0;
        rbeat(1'b1);
        wait_rfin(3);
        chk("t4_len1", rack_at_rfin - r0, 1);

        // 5: reset in the middle of a write burst
        b0 = n_beat;
        ddr_wraddr = 25'h1000; wr_length = 10'd8; ddr_wr_req = 1'b1;
        wait_cmd(7);
        ddr_wr_req = 1'b0;
        for (int i = 0; i < 50 && n_beat - b0 < 3; i++) tick();
        chk("t5_beats_before_rst", n_beat - b0, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_outs", {ddr_wr_ack, mem_wvalid, mem_cmd_en, ddr_wr_finish}, 0);
        repeat (2) @(posedge clk_ref);
        #1 rst_n = 1'b1;
        ack_pend = 1'b0; ackd_prev = 1'b0; occ = 0; n_beat = n_din;
        f0 = n_wfin; c0 = n_cmd;
        repeat (10) tick();
        chk("t5_no_finish", n_wfin, f0);
        chk("t5_idle", n_cmd, c0);
        a0 = n_ack;
        ddr_wraddr = 25'h1234; wr_length = 10'd1; ddr_wr_req = 1'b1;
        wait_cmd(c0 + 1);
        ddr_wr_req = 1'b0;
        chk("t5_new_cmd", {7'd0, last_addr, 6'd0, last_len}, {7'd0, 25'h1234, 6'd0, 10'd1});
        wait_wfin(f0 + 1);
        chk("t5_len1_acks", n_ack - a0, 1);

        // 6: read with memory never returning data
        f0 = n_rfin;
        rd_length = 10'd2; ddr_rdaddr = 25'h40; ddr_rd_req = 1'b1;
        wait_cmd(n_cmd + 1);
        ddr_rd_req = 1'b0;
`ifdef DDR_SEQ_TIMEOUT_EN
        repeat (16) tick();
        chk("t6_no_early_finish", {n_rfin - f0, 31'd0, seq_err}, 0);
        tick();
        chk("t6_timeout_finish", n_rfin - f0, 1);
        chk("t6_seq_err", seq_err, 1);
`else
        repeat (40) tick();
        chk("t6_stalled", n_rfin - f0, 0);
        chk("t6_seq_err0", seq_err, 0);
        chk("t6_no_new_cmd", mem_cmd_en, 0);
        rbeat(1'b1);
        rbeat(1'b1);
        wait_rfin(f0 + 1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
